// File: rtl/x_input_loader.sv
// Row-major loader for the X operand matrix: accepts a stream of elements
// while the controller holds input_load_en, then flags the matrix complete.
module x_input_loader #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 8,
  parameter int COLS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_load_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              xload_done,
  input  logic [2:0]        rd_row,
  input  logic [1:0]        rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic [5:0]        load_count
);

  localparam int TOTAL = ROWS * COLS;
  localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic              ready_q, done_q;
  logic              accept;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              rd_ok;
  logic [DATA_W-1:0] mem_q [TOTAL];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_load_en) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (!input_load_en) begin
          // Abort: drop the partial load, keep whatever was already written.
          state_d = IDLE;
          count_d = '0;
        end else if (in_valid) begin
          accept  = 1'b1;
          count_d = (count_q == 6'(TOTAL)) ? count_q : count_q + 6'd1;
          if (count_q == 6'(TOTAL - 1)) state_d = FULL;
        end
      end
      FULL: begin
        if (!input_load_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= (state_d == LOAD);
      done_q  <= (state_d == FULL);
    end
  end

  assign wr_idx = AW'(count_q);

  // NOTE: the buffer is reset explicitly because reset must read back as all
  // zeros; this costs a reset net per bit and rules out a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TOTAL; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wr_idx] <= in_data;
    end
  end

  assign rd_ok   = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign rd_idx  = AW'(int'(rd_row) * COLS + int'(rd_col));
  assign rd_data = rd_ok ? mem_q[rd_idx] : '0;

  assign in_ready   = ready_q;
  assign xload_done = done_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_x_input_loader.sv
// Directed bench for x_input_loader: a behavioural model tracks state/count
// and pushes expected writes to a scoreboard drained through the read port.
module tb_x_input_loader;

  logic       clk;
  logic       rst;
  logic       input_load_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       xload_done;
  logic [2:0] rd_row;
  logic [1:0] rd_col;
  logic [7:0] rd_data;
  logic [5:0] load_count;

  x_input_loader #(.DATA_W(8), .ROWS(8), .COLS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_load_en (input_load_en),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .xload_done    (xload_done),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_data       (rd_data),
    .load_count    (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_LOAD, M_FULL} mstate_e;
  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  mstate_e    m_state;
  int         m_cnt;
  logic [7:0] m_mem [32];
  wr_t        sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_cnt   = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    sb_q.delete();
  endtask

  // One clock: drive inputs, advance the model, then compare control outputs.
  task automatic cyc(input logic en, input logic v, input logic [7:0] d);
    input_load_en = en;
    in_valid      = v;
    in_data       = d;
    case (m_state)
      M_IDLE: if (en) begin m_state = M_LOAD; m_cnt = 0; end
      M_LOAD: begin
        if (!en) begin
          m_state = M_IDLE;
          m_cnt   = 0;
        end else if (v) begin
          m_mem[m_cnt] = d;
          sb_q.push_back('{addr: m_cnt, data: d});
          m_cnt++;
          if (m_cnt == 32) m_state = M_FULL;
        end
      end
      M_FULL: if (!en) m_state = M_IDLE;
      default: m_state = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    chk("in_ready",   in_ready,   m_state == M_LOAD);
    chk("xload_done", xload_done, m_state == M_FULL);
    chk("load_count", load_count, m_cnt);
  endtask

  task automatic peek(input string tag, input int row, input int col, input logic [7:0] exp);
    rd_row = 3'(row);
    rd_col = 2'(col);
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Pop every pending write and confirm it through the read port, one per cycle.
  task automatic drain(input logic en);
    wr_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_row = 3'(e.addr / 4);
      rd_col = 2'(e.addr % 4);
      cyc(en, 1'b0, 8'h00);
      chk("sb_rd_data", rd_data, e.data);
    end
  endtask

  initial begin
    rst = 1'b0;
    input_load_en = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    rd_row = 3'd2;
    rd_col = 2'd3;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_done", xload_done, 1'b0);
    chk("rst_count", load_count, 6'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full load k=0..31: done on the 33rd edge after enable
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, 1'b1, 8'(k));
      if (k == 30) chk("lat_not_done_32", xload_done, 1'b0);
    end
    chk("lat_done_33", xload_done, 1'b1);
    chk("full_count", load_count, 6'd32);
    peek("rd_2_3", 2, 3, 8'd11);
    cyc(1'b1, 1'b1, 8'd99);
    peek("full_ignores_valid", 0, 0, 8'd0);
    drain(1'b1);

    // Handoff to IDLE; valid pulses in IDLE write nothing
    cyc(1'b0, 1'b0, 8'h00);
    chk("handoff_done", xload_done, 1'b0);
    peek("handoff_7_3", 7, 3, 8'd31);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'd77);
    peek("idle_no_write_7_3", 7, 3, 8'd31);
    peek("idle_no_write_0_0", 0, 0, 8'd0);
    peek("out_of_range_none", 3, 1, m_mem[13]);

    // Gapped stream: valid toggles, data 50+k
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 64; i++) cyc(1'b1, (i % 2) == 0, 8'(50 + i / 2));
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'd200);
    chk("gap_count_sat", load_count, 6'd32);
    drain(1'b1);

    // Abort after 10 accepts, data 150+k
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 8'(150 + k));
    cyc(1'b0, 1'b1, 8'd222);
    chk("abort_count", load_count, 6'd0);
    peek("abort_no_accept", 2, 2, 8'd60);
    drain(1'b0);

    // Restart with 100+k: element 20 keeps old value until rewritten
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) cyc(1'b1, 1'b1, 8'(100 + k));
    peek("restart_elem5", 1, 1, 8'd105);
    peek("restart_elem20_old", 5, 0, 8'd70);
    cyc(1'b1, 1'b1, 8'd120);
    peek("restart_elem20_new", 5, 0, 8'd120);
    peek("restart_elem21_old", 5, 1, 8'd71);
    drain(1'b1);

    // Abort again, reload to count 17, then asynchronous reset mid-cycle
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 17; k++) cyc(1'b1, 1'b1, 8'(100 + k));
    chk("pre_rst_count", load_count, 6'd17);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_done", xload_done, 1'b0);
    chk("arst_count", load_count, 6'd0);
    for (int i = 0; i < 32; i++) begin
      rd_row = 3'(i / 4);
      rd_col = 2'(i % 4);
      #0.1;
      chk("arst_entry_zero", rd_data, 8'h00);
    end
    model_reset();
    input_load_en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back loads: k then 255-k
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, 8'(k));
    sb_q.delete();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, 8'(255 - k));
    peek("b2b_0_0", 0, 0, 8'hFF);
    peek("b2b_7_3", 7, 3, 8'd224);
    drain(1'b1);
    cyc(1'b0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
